// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone classic-cycle initiator.
// Provides: default bus widths, byte-increment helper, FSM state encoding,
// and the packed response payload carried on the response stream.
package wb_pkg;

    localparam int unsigned WB_AW_DEF   = 26;
    localparam int unsigned WB_DW_DEF   = 32;
    localparam int unsigned WB_DW_MAX   = 32;
    localparam int unsigned WB_BYTE_INC = WB_DW_DEF / 8;

    // FSM state encoding (plain constants for legacy tool flows)
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_BUS   = 2'd2;
    localparam state_t ST_GAP   = 2'd3;

    // Response payload; rdata sized for the widest legal data bus
    typedef struct packed {
        logic [WB_DW_MAX-1:0] rdata;
        logic                 err;
        logic                 last;
    } rsp_t;

    // Byte address increment per word for a given data width
    function automatic int unsigned byte_inc(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/wb_master_ctrl_if.sv
// Bundle of command, write-data, response and Wishbone master signals.
// Modport master: the initiator's view. Modport slave: the environment's view
// (command source, response sink and Wishbone target).
interface wb_master_ctrl_if
    import wb_pkg::*;
#(
    parameter int unsigned AW    = WB_AW_DEF,
    parameter int unsigned DW    = WB_DW_DEF,
    parameter int unsigned LEN_W = 4
) ();

    localparam int unsigned SW = DW / 8;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [AW-1:0]    cmd_addr;
    logic [SW-1:0]    cmd_sel;
    logic [LEN_W-1:0] cmd_len;

    logic             wd_valid;
    logic             wd_ready;
    logic [DW-1:0]    wd_data;

    logic             rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic             rsp_last;

    logic             wb_cyc_o;
    logic             wb_stb_o;
    logic             wb_we_o;
    logic [AW-1:0]    wb_adr_o;
    logic [SW-1:0]    wb_sel_o;
    logic [DW-1:0]    wb_dat_o;
    logic [DW-1:0]    wb_dat_i;
    logic             wb_ack_i;
    logic             wb_err_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_sel, cmd_len,
        output cmd_ready,
        input  wd_valid, wd_data,
        output wd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_last,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_sel, cmd_len,
        input  cmd_ready,
        output wd_valid, wd_data,
        input  wd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_last,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );

endinterface

// File: rtl/wb_ack_timer.sv
// Loadable down-counter with expiry flag, used to bound ACK/ERR wait time.
// Ports: clk/rst (async active-high), load + load_val reload the count,
// en decrements (saturating at zero), expired_c is high while count is zero.
module wb_ack_timer #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired_c
);

    logic [W-1:0] cnt_q;

    // Reload has priority over counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/wb_master_ctrl.sv
// Wishbone B4 classic-cycle initiator: turns one command (addr, dir, sel,
// beat count) into 1..2^LEN_W single cycles with CYC held across beats,
// returning one response per beat and aborting on ERR or ACK timeout.
// Ports: wb_clk_i, wb_rst_i (async active-high), bus (master modport carrying
// command, write-data, response and Wishbone signals).
module wb_master_ctrl
    import wb_pkg::*;
#(
    parameter int unsigned AW      = WB_AW_DEF,
    parameter int unsigned DW      = WB_DW_DEF,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_master_ctrl_if.master  bus
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [AW-1:0] ADR_INC  = AW'(byte_inc(DW));
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [DW-1:0]    dat_q, dat_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic             rsp_valid_q, rsp_valid_d;
    rsp_t             rsp_q, rsp_d;
    logic             tmr_load;
    logic             tmr_expired_c;

    // Wait bound for the current STB; reloaded on every entry to BUS
    wb_ack_timer #(.W(TW)) u_timer (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .load      (tmr_load),
        .load_val  (TMR_LOAD),
        .en        (state_q == ST_BUS),
        .expired_c (tmr_expired_c)
    );

    // State and registered outputs
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            dat_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            dat_q       <= dat_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        len_d       = len_q;
        beat_d      = beat_q;
        dat_d       = dat_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        rsp_valid_d = 1'b0;
        rsp_d       = '0;
        tmr_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    we_d   = bus.cmd_we;
                    adr_d  = bus.cmd_addr;
                    sel_d  = bus.cmd_sel;
                    len_d  = bus.cmd_len;
                    beat_d = '0;
                    cyc_d  = 1'b1;
                    if (bus.cmd_we) begin
                        stb_d   = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        stb_d    = 1'b1;
                        tmr_load = 1'b1;
                        state_d  = ST_BUS;
                    end
                end
            end
            ST_FETCH: begin
                if (bus.wd_valid) begin
                    dat_d    = bus.wd_data;
                    stb_d    = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = ST_BUS;
                end
            end
            ST_BUS: begin
                // ERR wins over ACK; an ACK in the final wait cycle still completes
                if (bus.wb_err_i || (!bus.wb_ack_i && tmr_expired_c)) begin
                    rsp_valid_d = 1'b1;
                    rsp_d.err   = 1'b1;
                    rsp_d.last  = 1'b1;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    state_d     = ST_IDLE;
                end else if (bus.wb_ack_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_d.rdata = we_q ? '0 : WB_DW_MAX'(bus.wb_dat_i);
                    adr_d       = adr_q + ADR_INC;
                    stb_d       = 1'b0;
                    if (beat_q == len_q) begin
                        rsp_d.last = 1'b1;
                        cyc_d      = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + LEN_W'(1);
                        state_d = we_q ? ST_FETCH : ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                stb_d    = 1'b1;
                tmr_load = 1'b1;
                state_d  = ST_BUS;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.wd_ready  = (state_q == ST_FETCH);

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_q.rdata[DW-1:0];
    assign bus.rsp_err   = rsp_q.err;
    assign bus.rsp_last  = rsp_q.last;

    assign bus.wb_cyc_o  = cyc_q;
    assign bus.wb_stb_o  = stb_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_adr_o  = adr_q;
    assign bus.wb_sel_o  = sel_q;
    assign bus.wb_dat_o  = dat_q;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Randomized self-checking bench for wb_master_ctrl. The bench acts as command
// source, write-data source and Wishbone target; expected bus addresses and
// responses come from the command fields and the target's chosen replies.
module tb_wb_master_ctrl;
    import wb_pkg::*;

    localparam int unsigned AW      = 26;
    localparam int unsigned DW      = 32;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned SW      = DW / 8;

    // Termination kinds for a beat
    localparam int K_TIMEOUT = 0;
    localparam int K_ERR     = 1;
    localparam int K_ACKERR  = 2;
    localparam int K_ACK     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    wb_master_ctrl_if #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) bus ();

    wb_master_ctrl #(.AW(AW), .DW(DW), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_sel   = '0;
        bus.cmd_len   = '0;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = '0;
        bus.wb_dat_i  = '0;
        bus.wb_ack_i  = 1'b0;
        bus.wb_err_i  = 1'b0;
    endtask

    // One full command. rnd=1 picks each beat's reply randomly; otherwise the
    // beat numbered abort_beat ends with abort_kind and all others are ACKed.
    task automatic run_cmd(input logic we, input logic [AW-1:0] addr,
                           input logic [SW-1:0] sel, input logic [LEN_W-1:0] len,
                           input bit rnd, input int abort_beat, input int abort_kind);
        int            beats;
        int            kind;
        int            gap;
        int            dly;
        int            n;
        bit            done;
        bit            exp_err;
        bit            exp_last;
        logic [AW-1:0] exp_adr;
        logic [DW-1:0] wdat;
        logic [DW-1:0] rdat;

        beats = int'(len) + 1;
        done  = 1'b0;
        wdat  = '0;
        rdat  = '0;

        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_sel   = sel;
        bus.cmd_len   = len;
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = ~we;
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_sel   = SW'($urandom);
        bus.cmd_len   = LEN_W'($urandom);

        for (int i = 0; i < beats && !done; i++) begin
            exp_adr = addr + AW'(i * int'(SW));
            if (we) begin
                gap = $urandom_range(0, 2);
                for (int k = 0; k < gap; k++) begin
                    chk("fetch_cyc", bus.wb_cyc_o, 1);
                    chk("fetch_stb", bus.wb_stb_o, 0);
                    step();
                end
                wdat          = $urandom;
                bus.wd_valid  = 1'b1;
                bus.wd_data   = wdat;
                chk("wd_ready", bus.wd_ready, 1);
                step();
                bus.wd_valid  = 1'b0;
                bus.wd_data   = $urandom;
            end else if (i > 0) begin
                chk("gap_stb", bus.wb_stb_o, 0);
                chk("gap_cyc", bus.wb_cyc_o, 1);
                step();
            end

            chk("stb", bus.wb_stb_o, 1);
            chk("cyc", bus.wb_cyc_o, 1);
            chk("adr", bus.wb_adr_o, exp_adr);
            chk("we", bus.wb_we_o, we);
            chk("sel", bus.wb_sel_o, sel);
            if (we) chk("dat_o", bus.wb_dat_o, wdat);

            if (rnd) begin
                n = $urandom_range(0, 29);
                kind = (n < 3) ? n : K_ACK;
            end else begin
                kind = (i == abort_beat) ? abort_kind : K_ACK;
            end

            if (kind == K_TIMEOUT) begin
                n = 0;
                while (bus.wb_stb_o && n < int'(TIMEOUT) + 8) begin
                    n++;
                    step();
                end
                chk("timeout_stb_len", n, TIMEOUT);
                exp_err = 1'b1;
            end else begin
                dly = $urandom_range(0, 3);
                for (int k = 0; k < dly; k++) begin
                    // stray handshakes while busy must be ignored
                    bus.cmd_valid = 1'($urandom);
                    bus.wd_valid  = 1'($urandom);
                    chk("busy_cmd_ready", bus.cmd_ready, 0);
                    chk("busy_no_rsp", bus.rsp_valid, 0);
                    step();
                end
                bus.cmd_valid = 1'b0;
                bus.wd_valid  = 1'b0;
                rdat          = $urandom;
                bus.wb_dat_i  = rdat;
                bus.wb_ack_i  = (kind != K_ERR);
                bus.wb_err_i  = (kind == K_ERR) || (kind == K_ACKERR);
                step();
                bus.wb_ack_i  = 1'b0;
                bus.wb_err_i  = 1'b0;
                bus.wb_dat_i  = $urandom;
                exp_err = (kind == K_ERR) || (kind == K_ACKERR);
            end

            exp_last = exp_err || (i == beats - 1);
            chk("rsp_valid", bus.rsp_valid, 1);
            chk("rsp_err", bus.rsp_err, exp_err);
            chk("rsp_last", bus.rsp_last, exp_last);
            chk("rsp_rdata", bus.rsp_rdata, (we || exp_err) ? '0 : rdat);
            if (exp_last) begin
                chk("end_cyc", bus.wb_cyc_o, 0);
                chk("end_stb", bus.wb_stb_o, 0);
                chk("end_cmd_ready", bus.cmd_ready, 1);
                done = 1'b1;
            end else begin
                chk("mid_cyc", bus.wb_cyc_o, 1);
                chk("mid_stb", bus.wb_stb_o, 0);
            end
        end
        step();
        chk("rsp_pulse_end", bus.rsp_valid, 0);
    endtask

    initial begin
        logic [AW-1:0] a;

        drive_idle();
        step();
        step();
        chk("rst_cyc", bus.wb_cyc_o, 0);
        chk("rst_stb", bus.wb_stb_o, 0);
        chk("rst_adr", bus.wb_adr_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_wd_ready", bus.wd_ready, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        rst = 1'b0;
        step();

        // Directed scenarios
        run_cmd(1'b0, AW'('h100), SW'('hF), LEN_W'(0), 1'b0, -1, K_ACK);
        run_cmd(1'b1, AW'('h200), SW'('hF), LEN_W'(3), 1'b0, -1, K_ACK);
        run_cmd(1'b0, AW'('h040), SW'('h3), LEN_W'(0), 1'b0, 0, K_TIMEOUT);
        run_cmd(1'b0, AW'('h080), SW'('hF), LEN_W'(2), 1'b0, 1, K_ERR);
        run_cmd(1'b1, AW'('h0C0), SW'('hC), LEN_W'(1), 1'b0, 0, K_ACKERR);
        a = '0;
        a = a - AW'(8);
        run_cmd(1'b0, a, SW'('hF), LEN_W'(3), 1'b0, -1, K_ACK);

        // Random commands
        for (int c = 0; c < 80; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = '0;
                a = a - AW'(4 * $urandom_range(1, 4));
            end else begin
                a = AW'($urandom) & ~AW'(SW - 1);
            end
            run_cmd(1'($urandom), a, SW'($urandom), LEN_W'($urandom), 1'b1, -1, K_ACK);
        end

        // Reset while STB is high in beat 1 of 4
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = AW'('h300);
        bus.cmd_sel   = SW'('hF);
        bus.cmd_len   = LEN_W'(3);
        step();
        bus.cmd_valid = 1'b0;
        chk("pre_rst_stb", bus.wb_stb_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cyc", bus.wb_cyc_o, 0);
        chk("async_rst_stb", bus.wb_stb_o, 0);
        chk("async_rst_rsp", bus.rsp_valid, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_rsp", bus.rsp_valid, 0);
        chk("post_rst_cyc", bus.wb_cyc_o, 0);
        run_cmd(1'b0, AW'('h400), SW'('hF), LEN_W'(1), 1'b0, -1, K_ACK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
